// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RV32I control unit sequencing fetch/decode/execute/memory/writeback
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   op, funct3, funct7b5  instruction fields from the IR
//   Zero                  combinational ALU zero flag for the current selects
//   mem_ready             memory done/accepting this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl datapath mux selects and ALU op
//   illegal_instr         one-cycle pulse in decode on an undecodable instruction
//   state_o               current state for debug
module mc_control_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       illegal_instr,
    output logic [3:0] state_o
);
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXER, S_EXEI,
        S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2, S_LUI, S_AUIPC, S_UNUSED
    } state_t;
    state_t     r_state;
    state_t     w_next;
    logic [3:0] w_funct_alu;
    logic [3:0] w_br_alu;
    logic       w_taken;
    logic       w_br_illegal;
    always_ff @(posedge clk)
        r_state <= reset ? state_t'(RESET_STATE) : w_next;
    assign state_o = r_state;
    // addi ignores funct7b5, so SUB is only possible from the register form
    always_comb begin
        w_funct_alu = ALU_ADD;
        case (funct3)
            3'b000: w_funct_alu = (r_state == S_EXER && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: w_funct_alu = ALU_SLL;
            3'b010: w_funct_alu = ALU_SLT;
            3'b011: w_funct_alu = ALU_SLTU;
            3'b100: w_funct_alu = ALU_XOR;
            3'b101: w_funct_alu = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110: w_funct_alu = ALU_OR;
            3'b111: w_funct_alu = ALU_AND;
        endcase
    end
    assign w_br_alu     = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
    // SUB sets Zero on equality; SLT/SLTU clear Zero when less-than, so
    // funct3[0] inverts the sense and funct3[2] flips from equality to ordering
    assign w_taken      = Zero ^ funct3[0] ^ funct3[2];
    assign w_br_illegal = funct3[2:1] == 2'b01;
    always_comb begin
        w_next        = S_FETCH;
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUControl    = ALU_ADD;
        illegal_instr = 1'b0;
        ImmSrc        = (op == OP_SW) ? 3'b001 :
                        (op == OP_BR) ? 3'b010 :
                        (op == OP_JAL) ? 3'b011 :
                        (op == OP_LUI || op == OP_AUIPC) ? 3'b100 : 3'b000;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXER;
                    OP_I:         w_next = S_EXEI;
                    OP_BR: begin
                        w_next        = w_br_illegal ? S_FETCH : S_BRANCH;
                        illegal_instr = w_br_illegal;
                    end
                    OP_JAL:       w_next = S_JAL;
                    OP_JALR:      w_next = S_JALR1;
                    OP_LUI:       w_next = S_LUI;
                    OP_AUIPC:     w_next = S_AUIPC;
                    default:      illegal_instr = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                w_next = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                w_next   = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXER: begin
                ALUSrcA    = 2'b10;
                ALUControl = w_funct_alu;
                w_next     = S_ALUWB;
            end
            S_EXEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = w_funct_alu;
                w_next     = S_ALUWB;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = w_br_alu;
                PCWrite    = w_taken;
            end
            S_JAL, S_JALR2: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                w_next  = S_ALUWB;
            end
            S_JALR1: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = S_JALR2;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                w_next  = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                w_next  = S_ALUWB;
            end
            default: w_next = S_FETCH;
        endcase
        // reset abandons the instruction: no state-changing strobe may escape
        if (reset) begin
            PCWrite       = 1'b0;
            IRWrite       = 1'b0;
            MemWrite      = 1'b0;
            RegWrite      = 1'b0;
            illegal_instr = 1'b0;
        end
    end
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: scoreboard bench driving instruction sequences into mc_control_fsm
module tb_mc_control_fsm;
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4;
    localparam logic [3:0] A_SLT = 4'd5, A_SLTU = 4'd6, A_SLL = 4'd7, A_SRL = 4'd8, A_SRA = 4'd9;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RR = 7'b0110011, II = 7'b0010011;
    localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111;
    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, memw, irw, regw, ill;
        logic [1:0] rs, sa, sb;
        logic [2:0] imm;
        logic [3:0] alu;
    } exp_t;
    typedef int plist_t[$];
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl, state_o;
    exp_t       q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    mc_control_fsm dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .illegal_instr(illegal_instr), .state_o(state_o)
    );
    always #5 clk = ~clk;
    function automatic bit is_legal(logic [6:0] o, logic [2:0] f3);
        if (o == BR) return !(f3 == 3'd2 || f3 == 3'd3);
        return o inside {LW, SW, RR, II, JAL, JALR, LUI, AUIPC};
    endfunction
    function automatic logic [2:0] imm_of(logic [6:0] o);
        if (o == SW) return 3'd1;
        if (o == BR) return 3'd2;
        if (o == JAL) return 3'd3;
        if (o == LUI || o == AUIPC) return 3'd4;
        return 3'd0;
    endfunction
    // state sequence an instruction walks through, from its class alone
    function automatic plist_t phases(logic [6:0] o, logic [2:0] f3);
        if (!is_legal(o, f3)) return '{0, 1};
        case (o)
            LW:      return '{0, 1, 2, 3, 4};
            SW:      return '{0, 1, 2, 5};
            RR:      return '{0, 1, 6, 8};
            II:      return '{0, 1, 7, 8};
            BR:      return '{0, 1, 9};
            JAL:     return '{0, 1, 10, 8};
            JALR:    return '{0, 1, 11, 12, 8};
            LUI:     return '{0, 1, 13, 8};
            default: return '{0, 1, 14, 8};
        endcase
    endfunction
    function automatic logic [3:0] alu_of(logic [2:0] f3, logic f7, bit is_r);
        logic [3:0] tbl [8] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
        if (f3 == 3'd0 && is_r && f7) return A_SUB;
        if (f3 == 3'd5 && f7) return A_SRA;
        return tbl[f3];
    endfunction
    function automatic exp_t model(int st, logic [6:0] o, logic [2:0] f3, logic f7,
                                   logic mr, logic z, logic r);
        exp_t e = '0;
        e.st  = 4'(st);
        e.alu = A_ADD;
        e.imm = imm_of(o);
        case (st)
            0:  begin e.sb = 2'd2; e.rs = 2'd2; e.irw = mr; e.pcw = mr; end
            1:  begin e.sa = 2'd1; e.sb = 2'd1; e.ill = !is_legal(o, f3); end
            2:  begin e.sa = 2'd2; e.sb = 2'd1; end
            3:  e.adr = 1'b1;
            4:  begin e.rs = 2'd1; e.regw = 1'b1; end
            5:  begin e.adr = 1'b1; e.memw = 1'b1; end
            6:  begin e.sa = 2'd2; e.alu = alu_of(f3, f7, 1); end
            7:  begin e.sa = 2'd2; e.sb = 2'd1; e.alu = alu_of(f3, f7, 0); end
            8:  e.regw = 1'b1;
            9:  begin
                e.sa  = 2'd2;
                e.alu = (f3 < 3'd4) ? A_SUB : (f3 < 3'd6) ? A_SLT : A_SLTU;
                e.pcw = (f3 == 3'd0 || f3 == 3'd5 || f3 == 3'd7) ? z : !z;
            end
            10, 12: begin e.sa = 2'd1; e.sb = 2'd2; e.pcw = 1'b1; end
            11: begin e.sa = 2'd2; e.sb = 2'd1; end
            13: begin e.sa = 2'd3; e.sb = 2'd1; end
            14: begin e.sa = 2'd1; e.sb = 2'd1; end
            default: ;
        endcase
        if (r) {e.pcw, e.irw, e.memw, e.regw, e.ill} = '0;
        return e;
    endfunction
    // stalls < 0: random mem_ready; otherwise fetch sees mem_ready=1 and the
    // memory states see exactly `stalls` not-ready cycles. zf < 0: random Zero.
    task automatic do_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input int stalls, input int zf, input int rst_st);
        plist_t p;
        int     n;
        bit     waits;
        logic   mr, z, r;
        p = phases(o, f3);
        foreach (p[i]) begin
            n = 0;
            waits = p[i] == 0 || p[i] == 3 || p[i] == 5;
            do begin
                mr = (stalls < 0) ? (($urandom_range(3) != 0) || n >= 3) : (p[i] == 0 || n >= stalls);
                z  = (zf < 0) ? 1'($urandom_range(1)) : zf[0];
                r  = p[i] == rst_st;
                @(posedge clk);
                #1;
                reset = r; mem_ready = mr; Zero = z; op = o; funct3 = f3; funct7b5 = f7;
                q.push_back(model(p[i], o, f3, f7, mr, z, r));
                n++;
                if (r) return;
            end while (waits && !mr);
        end
    endtask
    initial begin : monitor
        exp_t e, a;
        forever begin
            @(negedge clk);
            cyc++;
            if (q.size() != 0) begin
                e = q.pop_front();
                a = {state_o, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr,
                     ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL ctrl cycle %0d: got st=%0d pcw%b adr%b mw%b irw%b rw%b ill%b rs%b sa%b sb%b imm%b alu%0d, want st=%0d pcw%b adr%b mw%b irw%b rw%b ill%b rs%b sa%b sb%b imm%b alu%0d",
                             cyc, a.st, a.pcw, a.adr, a.memw, a.irw, a.regw, a.ill, a.rs, a.sa, a.sb, a.imm, a.alu,
                             e.st, e.pcw, e.adr, e.memw, e.irw, e.regw, e.ill, e.rs, e.sa, e.sb, e.imm, e.alu);
                end
            end
        end
    end
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: run did not complete, %0d vectors applied", vectors);
        $fatal(1, "timeout");
    end
    initial begin : stimulus
        logic [6:0] ops [9] = '{LW, SW, RR, II, BR, JAL, JALR, LUI, AUIPC};
        logic [6:0] o;
        repeat (2) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            q.push_back(model(0, op, funct3, funct7b5, mem_ready, Zero, 1'b1));
        end
        do_instr(RR, 3'd0, 1'b1, 0, -1, -1);
        do_instr(BR, 3'd0, 1'b0, 0, 1, -1);
        do_instr(BR, 3'd1, 1'b0, 0, 1, -1);
        do_instr(LW, 3'd2, 1'b0, 2, -1, -1);
        do_instr(JALR, 3'd0, 1'b0, 0, -1, -1);
        do_instr(7'd0, 3'd0, 1'b0, 0, -1, -1);
        do_instr(SW, 3'd2, 1'b0, 0, -1, 5);
        do_instr(II, 3'd0, 1'b1, 0, -1, -1);
        do_instr(II, 3'd5, 1'b1, 0, -1, -1);
        do_instr(BR, 3'd3, 1'b0, 0, 0, -1);
        for (int k = 0; k < 400; k++) begin
            o = ($urandom_range(9) == 0) ? 7'($urandom) : ops[$urandom_range(8)];
            do_instr(o, 3'($urandom), 1'($urandom), -1, -1,
                     ($urandom_range(39) == 0) ? int'($urandom_range(14)) : -1);
        end
        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
